// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path: active-low hex glyphs,
// the blank pattern and a constant-foldable clog2.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low abcdefg, seg[6]=a ... seg[0]=g, indexed by nibble value.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with per-slot blanking,
// per-digit enable/decimal point and global brightness. Optional blink: SEG7_BLINK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 200,
  parameter int BLANK_CYC = 4,
  parameter int BRIGHT_W  = 4
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int CW      = clog2(SCAN_DIV);
  localparam int IW      = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam int PW      = CW + BRIGHT_W;
  localparam int LIT_MAX = SCAN_DIV - BLANK_CYC;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        snap_nib_q, snap_nib_d;
  logic              snap_dp_q, snap_dp_d;
  logic              snap_en_q, snap_en_d;
  logic [CW-1:0]     snap_on_q, snap_on_d;

  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_tick_q, frame_tick_d;

  logic [3:0]        nib [DIGITS];
  logic [PW-1:0]     on_full;
  logic [CW-1:0]     on_len;
  logic              slot_start, slot_end, last_digit, lit, blink_off;
  logic [6:0]        dec_seg;

  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    assign nib[i] = digit_data[4*i +: 4];
  end

  assign slot_start = (cnt_q == '0);
  assign slot_end   = (cnt_q == CW'(SCAN_DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));

  // Full-width product so the brightness scaling never truncates before the shift.
  assign on_full = PW'(LIT_MAX) * (PW'(brightness) + PW'(1));
  assign on_len  = CW'(on_full >> BRIGHT_W);

`ifdef SEG7_BLINK_EN
  localparam int FW = clog2(BLINK_FRAMES) + 1;

  logic [FW-1:0] frame_cnt_q;
  logic          blink_phase_q;

  assign blink_off = blink_phase_q & blink_mask[idx_q];

  // Phase flips once every BLINK_FRAMES completed frames, starting visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (slot_end && last_digit) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end
`else
  assign blink_off = 1'b0;
`endif

  seg7_hex_decode u_dec (
    .nibble_i (snap_nib_q),
    .seg_o    (dec_seg)
  );

  assign lit = snap_en_q && (cnt_q >= CW'(BLANK_CYC))
            && ((cnt_q - CW'(BLANK_CYC)) < snap_on_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    snap_nib_d = snap_nib_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    snap_on_d  = snap_on_q;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = last_digit ? '0 : idx_q + IW'(1);
    end

    if (slot_start) begin
      snap_nib_d = nib[idx_q];
      snap_dp_d  = dp_in[idx_q];
      snap_en_d  = digit_en[idx_q] & ~blink_off;
      snap_on_d  = on_len;
    end

    an_d         = lit ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d        = lit ? dec_seg : SEG_BLANK;
    dp_n_d       = ~(lit & snap_dp_q);
    frame_tick_d = slot_start && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the snapshot is cleared as well so nothing stale can light after reset.
      snap_nib_q   <= '0;
      snap_dp_q    <= 1'b0;
      snap_en_q    <= 1'b0;
      snap_on_q    <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_nib_q   <= snap_nib_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      snap_on_q    <= snap_on_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at DIGITS=4, SCAN_DIV=16, BLANK_CYC=2, BRIGHT_W=2.
// Blink scenario is built when SEG7_BLINK_EN is defined.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] AN_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];
  int         exp_lit [4];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS    (4),
    .SCAN_DIV  (16),
    .BLANK_CYC (2),
    .BRIGHT_W  (2)
`ifdef SEG7_BLINK_EN
    , .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .brightness (brightness),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks output cycles c_from..c_to of one slot; output cycle c reflects slot count c.
  task automatic check_range(input int slot, input int c_from, input int c_to);
    logic lit;
    for (int c = c_from; c <= c_to; c++) begin
      @(posedge clk); #1;
      lit = (c >= 2) && (c < 2 + exp_lit[slot]);
      check($sformatf("an s%0d c%0d", slot, c),  32'(an),  32'(lit ? AN_SEL[slot] : 4'b1111));
      check($sformatf("seg s%0d c%0d", slot, c), 32'(seg), 32'(lit ? exp_seg[slot] : 7'b1111111));
      check($sformatf("dp_n s%0d c%0d", slot, c), 32'(dp_n), 32'(!(lit && exp_dp[slot])));
      check($sformatf("tick s%0d c%0d", slot, c), 32'(frame_tick), 32'(slot == 0 && c == 0));
    end
  endtask

  task automatic check_frame();
    for (int s = 0; s < 4; s++) check_range(s, 0, 15);
  endtask

  // Asserts reset for two edges; returns with reset released and the scan about to start.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst an",   32'(an),         32'hF);
    check("rst seg",  32'(seg),        32'h7F);
    check("rst dp_n", 32'(dp_n),       32'h1);
    check("rst tick", 32'(frame_tick), 32'h0);
    @(posedge clk); #1;
    check("rst hold tick", 32'(frame_tick), 32'h0);
    reset = 1'b1;
  endtask

  task automatic set_exp_8f10();
    exp_seg = '{7'b0000001, 7'b1001111, 7'b0111000, 7'b0000000};
    exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_lit = '{14, 14, 14, 14};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    digit_data = 16'h8F10;
    dp_in      = 4'b0000;
    digit_en   = 4'b1111;
    brightness = 2'd3;
`ifdef SEG7_BLINK_EN
    blink_mask = 4'b0000;
`endif

    // Full brightness, all digits on: 14-cycle lit window after 2 blank cycles.
    do_reset();
    set_exp_8f10();
    check_frame();
    check_frame();

    // Minimum brightness: (14*1)>>2 = 3 lit cycles.
    brightness = 2'd0;
    exp_lit = '{3, 3, 3, 3};
    check_frame();

    // Digit 2 disabled keeps its slot dark; decimal point on digit 0 only.
    brightness = 2'd3;
    digit_en   = 4'b1011;
    dp_in      = 4'b0001;
    exp_lit = '{14, 14, 0, 14};
    exp_dp  = '{1'b1, 1'b0, 1'b0, 1'b0};
    check_frame();

    // Data change mid slot 1 only takes effect at each digit's next slot.
    digit_en = 4'b1111;
    dp_in    = 4'b0000;
    set_exp_8f10();
    check_range(0, 0, 15);
    check_range(1, 0, 4);
    digit_data = 16'h8F23;
    check_range(1, 5, 15);
    check_range(2, 0, 15);
    check_range(3, 0, 15);
    exp_seg[0] = 7'b0000110;
    exp_seg[1] = 7'b0010010;
    check_frame();

    // Reset while slot 2 is mid-window; scan restarts from digit 0 with a fresh tick.
    check_range(0, 0, 15);
    check_range(1, 0, 15);
    check_range(2, 0, 8);
    do_reset();
    check_frame();

`ifdef SEG7_BLINK_EN
    // Two visible frames, two with digit 2 blanked, then visible again.
    blink_mask = 4'b0100;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      exp_lit[2] = (f == 2 || f == 3) ? 0 : 14;
      check_frame();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the lab board display path. It drives up to 16 common-anode digits from a packed hex register and scans one digit per slot. Each slot has a blanking interval against ghosting, per-digit enable and decimal point, and a global brightness duty cycle. It sits between the AXI-lite register slave that holds the display value and the board AN/segment pins.

## Interface
- DIGITS, 8: number of digits scanned, 1..16
- SCAN_DIV, 200: clk cycles per digit slot, ≥ BLANK_CYC+2
- BLANK_CYC, 4: cycles at slot start with all anodes off, ≥ 1
- BRIGHT_W, 4: brightness code width, 1..8
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- digit_data  in  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i]
- dp_in  in  DIGITS  decimal point request per digit, active-high
- digit_en  in  DIGITS  digit enable; 0 keeps that anode off for its slot
- brightness  in  BRIGHT_W  duty code; 2^BRIGHT_W−1 = full window
- an  out  DIGITS  anode select, active-low, at most one low
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g
- dp_n  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at the start of each full scan

## Operation
- Slot counter cnt runs 0..SCAN_DIV−1 and wraps. Digit index idx advances 0..DIGITS−1 and wraps when cnt==SCAN_DIV−1.
- Slot start (cnt==0): snapshot the idx nibble, dp_in[idx], digit_en[idx] and on_len. Input changes mid-slot have no effect until that digit's next slot.
- on_len = ((SCAN_DIV−BLANK_CYC)·(brightness+1)) >> BRIGHT_W. Compute at full width, clog2(SCAN_DIV)+BRIGHT_W bits, with no truncation before the shift.
- Lit condition: cnt ≥ BLANK_CYC, cnt−BLANK_CYC < on_len, and the snapshot enable is 1. While lit, an[idx]=0 and seg/dp_n are driven from the snapshot. While not lit, an is all ones, seg=7'b1111111 and dp_n=1.
- Hex map (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000, c=1110010, d=1000010, E=0110000, F=0111000
- A disabled digit still consumes its slot, so scan timing does not depend on digit_en.

## Timing
- Reset (reset==0 at a clk edge): cnt=0, idx=0, snapshot cleared, an all ones, seg=7'b1111111, dp_n=1, frame_tick=0. Reset takes effect on that edge even mid-slot or mid-frame.
- an, seg, dp_n and frame_tick are registered with 1-cycle latency. The outputs in cycle k+1 reflect cnt/idx/snapshot in cycle k.
- frame_tick is high for exactly one cycle: the cycle after cnt==0 with idx==0. It does not pulse in the first cycle after reset release; the first pulse follows the first cnt==0, idx==0 state.
- DIGITS==1: idx stays 0 and frame_tick pulses every slot.
- Brightness max: the lit window is exactly SCAN_DIV−BLANK_CYC cycles. An on_len of 0 (possible with large BLANK_CYC) leaves the digit dark for the whole slot.

## Configuration
- SEG7_BLINK_EN defined: adds input blink_mask[DIGITS-1:0] and parameter BLINK_FRAMES (default 64).
  - A frame counter counts frame_ticks; blink_phase toggles every BLINK_FRAMES frames and resets to 0 (visible).
  - When blink_phase==1, digits whose mask bit was set at slot start are treated as disabled.
- SEG7_BLINK_EN undefined: no port, no counter; behaviour is exactly as above.

## Structure
- seg7_pkg: the 16-entry SEG_HEX active-low pattern constant, SEG_BLANK=7'b1111111, and a clog2 function.
- Sub-module seg7_hex_decode: combinational nibble→seg lookup using SEG_HEX. It is instantiated once, on the snapshot nibble.
- All counters and the snapshot live in seg7_scan_ctrl.

## Test plan
Configuration for all scenarios: DIGITS=4, SCAN_DIV=16, BLANK_CYC=2, BRIGHT_W=2.
- Reset then digit_data=16'h8F10, all enabled, brightness=3 → per slot: 2 dark cycles, then 14 cycles with an=1110 and seg=0000001, then 1101/1001111, 1011/0111000, 0111/0000000; frame_tick every 64 cycles.
- brightness=0 → lit window is 3 cycles (14·1>>2) after the 2 blank cycles; all outputs dark for the remaining 11.
- digit_en=4'b1011, dp_in=4'b0001 → slot 2 fully dark with slot length unchanged; dp_n=0 only while digit 0 is lit.
- digit_data changed at cnt=5 of slot 1 → slot 1 keeps its old pattern; the new value appears from slot 1's next occurrence.
- reset asserted at cnt=9 of slot 2 → next cycle: an=1111, seg=1111111, frame_tick=0; scan restarts at idx 0.
- SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0100 → digit 2 lit for frames 0–1, dark for frames 2–3, then repeats; other digits are unaffected.
